// File: rtl/acc_traffic_gen_if.sv
// -----------------------------------------------------------------------------
// decoupled_vr_if
//   Decoupled valid/ready channel carrying one word per handshake. A transfer
//   completes on the clock edge where valid & ready are both high.
//
//   Parameter W : word width (instantiate with $bits(fifo_ctrl_pkg::data_t)).
//
//   Signals:
//     valid  producer -> consumer  word on data is offered
//     ready  consumer -> producer  consumer accepts the offered word
//     data   producer -> consumer  payload, must hold while valid & !ready
//
//   Modports:
//     master : producer end (drives valid/data, observes ready)
//     slave  : consumer end (drives ready, observes valid/data)
// -----------------------------------------------------------------------------
interface decoupled_vr_if #(
    parameter int W = 32
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/acc_traffic_gen.sv
// -----------------------------------------------------------------------------
// acc_traffic_gen
//   Bring-up / characterisation partner for an accelerator with two decoupled
//   valid/ready channels. Streams tx_words incrementing words (base_data,
//   base_data+1, ...) into the accelerator's consumer side and accepts
//   rx_words words from its producer side, reporting the received count,
//   their XOR signature, the run length and whether the run timed out.
//
//   Optional feature macro: COHORT_TGEN_BACKPRESSURE_EN
//     When defined, acc_out.ready is gated by a phase bit that is low in the
//     first run cycle and toggles every run cycle, forcing producer stalls.
//
//   Ports:
//     clk, rst_n      clock; synchronous active-low reset
//     start           one-cycle run request, honoured only when idle
//     tx_words        words to transmit        (latched at start)
//     rx_words        words to receive         (latched at start)
//     base_data       first transmitted word   (latched at start)
//     timeout_cycles  run-length limit, 0 = off (latched at start)
//     acc_in          master: words into the accelerator
//     acc_out         slave : words out of the accelerator
//     busy            high while running or completing
//     done            one-cycle completion pulse
//     timed_out       last run ended by timeout
//     rx_count        words received in last/current run
//     run_cycles      cycles spent running (saturating)
//     rx_xor          XOR of all received words
// -----------------------------------------------------------------------------
package fifo_ctrl_pkg;
    typedef logic [31:0] data_t;
endpackage

module acc_traffic_gen
    import fifo_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [15:0]           tx_words,
    input  logic [15:0]           rx_words,
    input  data_t                 base_data,
    input  logic [31:0]           timeout_cycles,
    decoupled_vr_if.master        acc_in,
    decoupled_vr_if.slave         acc_out,
    output logic                  busy,
    output logic                  done,
    output logic                  timed_out,
    output logic [15:0]           rx_count,
    output logic [31:0]           run_cycles,
    output data_t                 rx_xor
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;

    logic [15:0] tx_cnt_q;
    logic [15:0] rx_cnt_q;
    logic [15:0] tx_words_q;
    logic [15:0] rx_words_q;
    data_t       base_q;
    logic [31:0] timeout_q;
    logic [31:0] run_cycles_q;
    data_t       rx_xor_q;
    logic        timed_out_q;

    logic        tx_valid;
    logic        rx_ready;
    logic        tx_fire;
    logic        rx_fire;
    logic [31:0] run_cycles_inc;
    logic        complete;
    logic        expire;

    // Both channel controls come from registered state only, so valid never
    // depends combinationally on ready and data stays put while stalled.
    assign tx_valid = (state_q == S_RUN) && (tx_cnt_q < tx_words_q);

`ifdef COHORT_TGEN_BACKPRESSURE_EN
    logic phase_q;
    assign rx_ready = (state_q == S_RUN) && (rx_cnt_q < rx_words_q) && phase_q;
`else
    assign rx_ready = (state_q == S_RUN) && (rx_cnt_q < rx_words_q);
`endif

    assign acc_in.valid  = tx_valid;
    assign acc_in.data   = base_q + data_t'(tx_cnt_q);
    assign acc_out.ready = rx_ready;

    assign tx_fire = tx_valid & acc_in.ready;
    assign rx_fire = rx_ready & acc_out.valid;

    assign run_cycles_inc = (run_cycles_q == 32'hFFFF_FFFF) ? run_cycles_q
                                                            : run_cycles_q + 32'd1;

    // Completion uses the registered counts, so it is seen one cycle after
    // the final handshake and takes priority over a coincident timeout.
    assign complete = (tx_cnt_q == tx_words_q) && (rx_cnt_q == rx_words_q);
    assign expire   = (timeout_q != 32'd0) && (run_cycles_inc == timeout_q);

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // -------------------------------------------------------------------------
    // FSM next-state logic
    // -------------------------------------------------------------------------
    // NOTE: state_d is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN: begin
                if (complete)    state_d = S_DONE;
                else if (expire) state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: latched configuration, counters and results
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_cnt_q     <= '0;
            rx_cnt_q     <= '0;
            tx_words_q   <= '0;
            rx_words_q   <= '0;
            base_q       <= '0;
            timeout_q    <= '0;
            run_cycles_q <= '0;
            rx_xor_q     <= '0;
            timed_out_q  <= 1'b0;
`ifdef COHORT_TGEN_BACKPRESSURE_EN
            phase_q      <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        tx_words_q   <= tx_words;
                        rx_words_q   <= rx_words;
                        base_q       <= base_data;
                        timeout_q    <= timeout_cycles;
                        tx_cnt_q     <= '0;
                        rx_cnt_q     <= '0;
                        run_cycles_q <= '0;
                        rx_xor_q     <= '0;
                        timed_out_q  <= 1'b0;
`ifdef COHORT_TGEN_BACKPRESSURE_EN
                        phase_q      <= 1'b0;
`endif
                    end
                end
                S_RUN: begin
                    if (tx_fire) tx_cnt_q <= tx_cnt_q + 16'd1;
                    if (rx_fire) begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                        rx_xor_q <= rx_xor_q ^ acc_out.data;
                    end
                    run_cycles_q <= run_cycles_inc;
                    if (!complete && expire) timed_out_q <= 1'b1;
`ifdef COHORT_TGEN_BACKPRESSURE_EN
                    phase_q <= ~phase_q;
`endif
                end
                default: ;
            endcase
        end
    end

    assign busy       = (state_q == S_RUN) || (state_q == S_DONE);
    assign done       = (state_q == S_DONE);
    assign timed_out  = timed_out_q;
    assign rx_count   = rx_cnt_q;
    assign run_cycles = run_cycles_q;
    assign rx_xor     = rx_xor_q;

endmodule

// File: doc/acc_traffic_gen.md
# acc_traffic_gen

Stream source/sink that drives the accelerator unit from the opposite end of its two decoupled valid/ready channels. It transmits a programmed number of words into the accelerator's consumer channel and receives a programmed number of words from its producer channel. It reports count, XOR signature, run length and timeout status. It sits in the fifo_controller acc_unit area as the bring-up and characterisation partner for any accelerator exposing that interface (dummy, AES, SHA).

## Interface
Parameters: none. Data width is `fifo_ctrl_pkg::data_t`.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle request to begin a run; sampled only in S_IDLE
- tx_words  in  16  words to transmit; sampled at start
- rx_words  in  16  words to receive; sampled at start
- base_data  in  data_t  first transmitted word; sampled at start
- timeout_cycles  in  32  run-length limit; 0 disables it; sampled at start
- acc_in  decoupled_vr_if.master  data_t  words into the accelerator's consumer side
- acc_out  decoupled_vr_if.slave  data_t  words from the accelerator's producer side
- busy  out  1  high in S_RUN and S_DONE
- done  out  1  one-cycle completion pulse
- timed_out  out  1  last run ended by timeout
- rx_count  out  16  words received in the last or current run
- run_cycles  out  32  cycles spent in S_RUN
- rx_xor  out  data_t  XOR of all received words

## Operation
- States:
  - S_IDLE: on start, latch the inputs, clear the counters, rx_xor and timed_out, then go to S_RUN. A start seen in any other state is ignored.
  - S_RUN: the transmit and receive sides run concurrently and independently.
  - S_DONE: lasts one cycle, then S_IDLE.
- Transmit side:
  - acc_in.valid = S_RUN & (tx_cnt < tx_words).
  - acc_in.data = base_data + tx_cnt; tx_cnt is zero-extended to data_t and the sum is taken modulo data_t width.
  - tx_cnt increments on valid & ready.
  - Data comes from registered state only, so it stays stable while stalled.
- Receive side:
  - acc_out.ready = S_RUN & (rx_cnt < rx_words), gated by the backpressure phase when that option is compiled in.
  - On valid & ready: rx_cnt increments and rx_xor ^= data.
  - Once rx_words are received, ready stays low, so surplus words stall at the accelerator.
- run_cycles increments every S_RUN cycle and saturates at 0xFFFF_FFFF.
- Exit from S_RUN, evaluated each S_RUN cycle:
  - Completion, checked first: registered tx_cnt == tx_words and rx_cnt == rx_words. Go to S_DONE with timed_out = 0.
  - Timeout: timeout_cycles != 0 and the incremented run_cycles equals timeout_cycles. Go to S_DONE with timed_out = 1.
- Results (rx_count, rx_xor, run_cycles, timed_out) hold until the next accepted start.
- tx_words = 0 means nothing is transmitted; rx_words = 0 means nothing is received.

## Timing
- Reset values: state S_IDLE; all outputs 0, including acc_in.valid, acc_in.data and acc_out.ready; counters and latched inputs 0.
- Reset mid-run takes effect on the next edge; valid and ready are low in the following cycle and no partial result is preserved.
- Latency:
  - start at cycle 0 puts the block in S_RUN at cycle 1.
  - The first acc_in.valid is at cycle 1, when tx_words > 0.
  - Completion is detected in the cycle after the last handshake; done is high in the following cycle.
- tx_words = rx_words = 0: S_RUN at cycle 1, done at cycle 2, run_cycles = 1.
- Handshakes complete on the clock edge where valid & ready.
  - acc_in.valid never drops without a handshake, except on reset or timeout.
  - acc_in.valid does not depend combinationally on acc_in.ready.
- Counters are 16 bit and compare with ==. They do not wrap because they stop at the target; 0xFFFF words are allowed.

## Configuration
- COHORT_TGEN_BACKPRESSURE_EN defined:
  - A phase bit clears at start and toggles every S_RUN cycle.
  - acc_out.ready is additionally ANDed with the phase, so it is low in the first S_RUN cycle and high every other cycle after that.
  - This exercises producer stalls.
- Not defined: the phase logic is absent and ready follows only the state and count condition.

## Test plan
- Loopback: bench registers acc_in into acc_out with a 1-cycle delay. Stimulus: tx = rx = 4, base 0x1, timeout 0. Required: acc_in data sequence 1, 2, 3, 4; one done pulse; rx_count = 4; rx_xor = 0x4; timed_out = 0.
- Zero-length run: tx = rx = 0. Required: done at cycle 2 after start; run_cycles = 1; rx_xor = 0.
- Transmit stall: acc_in.ready held low for 5 cycles, tx = 2, base 0xA. Required: valid stays high with data 0xA throughout the stall; next word 0xB after ready rises.
- Timeout: rx = 3, sink never valid, timeout = 20. Required: done after 20 S_RUN cycles; timed_out = 1; run_cycles = 20; rx_count = 0.
- Reset mid-run: rst_n low in the 3rd S_RUN cycle. Required: busy, valid and ready are 0 in the next cycle; all results are 0.
- Backpressure (macro defined): producer valid held high, rx = 4. Required: ready pattern 0,1,0,1,…; 4 words received over 8 S_RUN cycles.
